mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle signed Booth multiplier (start/valid interface, WIDTH-cycle compute) among NREQ requesters. It accepts one operand pair at a time and drives the multiplier with stable operands and a single-cycle start. It returns the 2·WIDTH product to the granted requester through a valid/ready response handshake, and reports a timeout if the multiplier never completes. It sits between client blocks and the multiplier instance, which shares its clk/rst.

## Interface
- WIDTH, 8, operand width; multiplier product width is 2·WIDTH
- NREQ, 4, number of requesters (≥2)
- TIMEOUT, 2·WIDTH+4, maximum BUSY cycles before error; must be > WIDTH+1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot accept strobe; request i is accepted when req_valid[i] and req_ready[i] are both 1
- req_x  in  NREQ·WIDTH  signed multiplicand, requester i at bits [i·WIDTH +: WIDTH]
- req_y  in  NREQ·WIDTH  signed multiplier, same packing
- resp_valid  out  NREQ  one-hot result available for the granted requester
- resp_ready  in  NREQ  requester accepts result
- resp_z  out  2·WIDTH  signed product, shared; meaningful only while any resp_valid is 1
- resp_err  out  1  qualifies resp_valid: multiplier timed out, and resp_z=0
- mul_start  out  1  single-cycle start to multiplier
- mul_x, mul_y  out  WIDTH  signed operands to multiplier
- mul_z  in  2·WIDTH  multiplier product
- mul_valid  in  1  multiplier one-cycle completion pulse
- busy  out  1  high in every state except IDLE

## Operation
- Registers: state, grant index g, round-robin pointer ptr, op_x/op_y, resp_z, resp_err, timeout counter tcnt.
- IDLE:
  - req_ready is combinational. Search req_valid starting at ptr, wrapping modulo NREQ; the first set bit wins as g.
  - req_ready[g]=1 in the same cycle. Latch req_x/req_y slice g into op_x/op_y and go to ISSUE.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- ISSUE: mul_start=1 for exactly this cycle. Go to BUSY with tcnt=0.
- BUSY:
  - If mul_valid is 1, capture mul_z into resp_z, set resp_err=0, and go to RESP.
  - Otherwise, if tcnt==TIMEOUT-1, set resp_z=0 and resp_err=1, then go to RESP.
  - Otherwise, tcnt+1.
- RESP:
  - resp_valid[g]=1 and resp_z/resp_err are held.
  - If resp_ready[g] is 1, go to IDLE and set ptr=(g+1) mod NREQ. resp_ready bits for other requesters are ignored.
- mul_x/mul_y = op_x/op_y in all states. They are stable from the cycle after accept until the next accept, because the multiplier samples operands in its own idle state.
- Only one operation is outstanding. No new request is accepted before the RESP handshake completes.
- ptr advances only on a completed response. Errored responses also advance ptr.
- A mul_valid pulse outside BUSY is ignored.
- Reset values: state=IDLE, ptr=0, g=0, op_x=op_y=0, resp_z=0, resp_err=0, tcnt=0. All outputs are 0: req_ready, resp_valid, mul_start, busy, mul_x, mul_y.
- Reset mid-operation: immediate return to IDLE and the in-flight result is discarded. The multiplier is reset by the same rst.
- req_valid may drop before it is granted, with no side effects. Operands are sampled only in the accept cycle.

## Timing
- Accept in cycle T (IDLE).
- mul_start in cycle T+1.
- Multiplier computes during T+2 … T+1+WIDTH.
- mul_valid in cycle T+2+WIDTH.
- resp_valid from cycle T+3+WIDTH. With WIDTH=8 and accept at cycle 0, resp_valid is first high at cycle 11.
- If resp_ready is high in the first RESP cycle, IDLE follows in the next cycle and the next accept can occur there. Minimum spacing between accepts is WIDTH+4 cycles.
- On timeout, resp_valid is first high at T+2+TIMEOUT, i.e. cycle 22 with defaults.
- The multiplier is always back in its idle state at least one cycle before the next mul_start.

## Test plan
- Single request: cycle 0, req_valid=0b0010, x1=-3, y1=5 → req_ready=0b0010 at cycle 0; mul_start at cycle 1; resp_valid=0b0010 at cycle 11 with resp_z=16'hFFF1 and resp_err=0.
- Contention: all four requesters assert at cycle 0 with x_i=i+1, y_i=2 and hold their requests, with resp_ready tied high → grants in order 0,1,2,3, accepts at cycles 0, 12, 24, 36; products 2, 4, 6, 8.
- Fairness: after requester 2 is served, requesters 0 and 3 both request → 3 is granted before 0.
- Backpressure and extremes: x=-128, y=-128, resp_ready held low for 5 cycles after resp_valid → resp_z=16'h4000 held stable; no mul_start and req_ready stays 0 until the handshake completes.
- Timeout: stub the multiplier so mul_valid never asserts → resp_valid at cycle 22 with resp_err=1 and resp_z=0; ptr advances.
- Reset: assert rst during BUSY (cycle 5) → all outputs are 0 immediately. After release, a new request for x=7, y=-6 yields resp_z=-42 (16'hFFD6).

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that shares one multi-cycle signed
// multiplier among NREQ requesters. One operation is in flight at a time.
// Each operation is accepted, issued, awaited (with a timeout) and then
// returned through a valid/ready response handshake.
module mul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2 * WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_x,
    input  logic [NREQ*WIDTH-1:0]   req_y,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [2*WIDTH-1:0]      resp_z,
    output logic                    resp_err,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_x,
    output logic [WIDTH-1:0]        mul_y,
    input  logic [2*WIDTH-1:0]      mul_z,
    input  logic                    mul_valid,
    output logic                    busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   g;
    logic [IW-1:0]   ptr;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [TW-1:0]   tcnt;

    logic [WIDTH-1:0] x_slice [NREQ];
    logic [WIDTH-1:0] y_slice [NREQ];
    logic [IW:0]      pick;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;

    // Scan the request vector starting at the round-robin pointer, wrapping
    // around; the first pending requester found wins.
    function automatic logic [IW:0] find_next(input logic [NREQ-1:0] v,
                                              input logic [IW-1:0]   start);
        logic [IW:0] r;
        int          idx;
        r = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(start) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!r[IW] && v[IW'(idx)]) r = {1'b1, IW'(idx)};
        end
        return r;
    endfunction

    genvar i;
    for (i = 0; i < NREQ; i++) begin : g_unpack
        assign x_slice[i] = req_x[i*WIDTH +: WIDTH];
        assign y_slice[i] = req_y[i*WIDTH +: WIDTH];
    end

    assign pick       = find_next(req_valid, ptr);
    assign pick_found = pick[IW];
    assign pick_idx   = pick[IW-1:0];

    // Accept strobe is combinational so the grant lands in the same cycle
    // the request is seen; it is forced low while reset is held.
    assign req_ready = (state == IDLE && !rst && pick_found) ? (ONE << pick_idx) : '0;

    // Operands stay parked on the multiplier inputs between accepts.
    assign mul_x = op_x;
    assign mul_y = op_y;

    // Sequencer: accept -> issue start -> wait for product or timeout -> respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            g          <= '0;
            ptr        <= '0;
            op_x       <= '0;
            op_y       <= '0;
            resp_z     <= '0;
            resp_err   <= 1'b0;
            tcnt       <= '0;
            mul_start  <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        g         <= pick_idx;
                        op_x      <= x_slice[pick_idx];
                        op_y      <= y_slice[pick_idx];
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    tcnt      <= '0;
                    state     <= BUSY;
                end
                BUSY: begin
                    if (mul_valid) begin
                        resp_z     <= mul_z;
                        resp_err   <= 1'b0;
                        resp_valid <= ONE << g;
                        state      <= RESP;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        resp_z     <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= ONE << g;
                        state      <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[g]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        ptr        <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed bench for mul_arbiter with a behavioural
// start/valid multiplier stub that can be switched off to force a timeout.
module tb_mul_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [2*WIDTH-1:0]    resp_z;
    logic                  resp_err;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_x;
    logic [WIDTH-1:0]      mul_y;
    logic [2*WIDTH-1:0]    mul_z;
    logic                  mul_valid;
    logic                  busy;

    logic mm_enable;
    logic mm_busy;
    int   mm_cnt;

    int checks_total  = 0;
    int checks_passed = 0;

    mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .resp_err   (resp_err),
        .mul_start  (mul_start),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_z      (mul_z),
        .mul_valid  (mul_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Multiplier stub: mul_valid pulses WIDTH+1 cycles after the start cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_busy   <= 1'b0;
            mm_cnt    <= 0;
            mul_valid <= 1'b0;
            mul_z     <= '0;
        end else begin
            mul_valid <= 1'b0;
            if (mm_busy) begin
                if (mm_cnt == 1) begin
                    mul_valid <= 1'b1;
                    mm_busy   <= 1'b0;
                end else begin
                    mm_cnt <= mm_cnt - 1;
                end
            end else if (mul_start && mm_enable) begin
                mm_busy <= 1'b1;
                mm_cnt  <= WIDTH;
                mul_z   <= $signed({{WIDTH{mul_x[WIDTH-1]}}, mul_x}) *
                           $signed({{WIDTH{mul_y[WIDTH-1]}}, mul_y});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int who, input logic [7:0] x, input logic [7:0] y);
        req_valid[who]           = 1'b1;
        req_x[who*WIDTH +: WIDTH] = x;
        req_y[who*WIDTH +: WIDTH] = y;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Runs one full transaction whose accept cycle is the current cycle.
    task automatic serve(input string tag, input int who, input logic [7:0] ex,
                         input logic [7:0] ey, input logic [15:0] ez);
        settle();
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << who));
        step();
        req_valid[who] = 1'b0;
        settle();
        checkOutput({tag, "_start"}, 32'(mul_start), 32'd1);
        checkOutput({tag, "_mulx"}, 32'(mul_x), 32'(ex));
        checkOutput({tag, "_muly"}, 32'(mul_y), 32'(ey));
        step();
        settle();
        checkOutput({tag, "_start_once"}, 32'(mul_start), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (8) step();
        settle();
        checkOutput({tag, "_early"}, 32'(resp_valid), 32'd0);
        step();
        settle();
        checkOutput({tag, "_rvalid"}, 32'(resp_valid), 32'(1 << who));
        checkOutput({tag, "_z"}, 32'(resp_z), 32'(ez));
        checkOutput({tag, "_err"}, 32'(resp_err), 32'd0);
        step();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_x      = '0;
        req_y      = '0;
        resp_ready = '0;
        mm_enable  = 1'b1;

        // Reset state, with requests pending to show req_ready is held low
        repeat (2) @(posedge clk);
        settle();
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rvalid", 32'(resp_valid), 32'd0);
        checkOutput("rst_start", 32'(mul_start), 32'd0);
        checkOutput("rst_mulx", 32'(mul_x), 32'd0);
        checkOutput("rst_muly", 32'(mul_y), 32'd0);
        checkOutput("rst_z", 32'(resp_z), 32'd0);
        checkOutput("rst_err", 32'(resp_err), 32'd0);
        step();
        rst       = 1'b0;
        req_valid = '0;
        step();

        // Contention: all four request together, served 0,1,2,3 every 12 cycles
        step();
        resp_ready = 4'hF;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'(i + 1), 8'd2);
        for (int i = 0; i < NREQ; i++) serve("cont", i, 8'(i + 1), 8'd2, 16'(2 * (i + 1)));
        settle();
        checkOutput("cont_idle", 32'(busy), 32'd0);

        // Single request with a negative operand
        step();
        applyStimulus(1, 8'hFD, 8'h05);
        serve("single", 1, 8'hFD, 8'h05, 16'hFFF1);
        settle();
        checkOutput("single_idle", 32'(busy), 32'd0);

        // Fairness: after 2 is served, 3 beats 0
        step();
        applyStimulus(2, 8'd10, 8'hF6);
        serve("fair2", 2, 8'd10, 8'hF6, 16'hFF9C);
        applyStimulus(0, 8'd3, 8'd3);
        applyStimulus(3, 8'hFE, 8'd4);
        serve("fair3", 3, 8'hFE, 8'd4, 16'hFFF8);
        serve("fair0", 0, 8'd3, 8'd3, 16'h0009);

        // Backpressure with extreme operands; other resp_ready bits are ignored
        resp_ready = 4'b1101;
        applyStimulus(1, 8'h80, 8'h80);
        settle();
        checkOutput("bp_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid[1] = 1'b0;
        applyStimulus(2, 8'd5, 8'd5);
        settle();
        checkOutput("bp_start", 32'(mul_start), 32'd1);
        checkOutput("bp_noaccept", 32'(req_ready), 32'd0);
        repeat (10) step();
        settle();
        checkOutput("bp_rvalid", 32'(resp_valid), 32'b0010);
        checkOutput("bp_z", 32'(resp_z), 32'h4000);
        for (int k = 0; k < 5; k++) begin
            step();
            settle();
            checkOutput("bp_hold_rvalid", 32'(resp_valid), 32'b0010);
            checkOutput("bp_hold_z", 32'(resp_z), 32'h4000);
            checkOutput("bp_hold_start", 32'(mul_start), 32'd0);
            checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        step();
        resp_ready = 4'hF;
        settle();
        checkOutput("bp_last_rvalid", 32'(resp_valid), 32'b0010);
        step();
        serve("bp_next", 2, 8'd5, 8'd5, 16'h0019);

        // Timeout: the stub never completes
        mm_enable = 1'b0;
        applyStimulus(3, 8'd2, 8'd2);
        settle();
        checkOutput("to_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid[3] = 1'b0;
        repeat (20) step();
        settle();
        checkOutput("to_early", 32'(resp_valid), 32'd0);
        checkOutput("to_busy", 32'(busy), 32'd1);
        step();
        settle();
        checkOutput("to_rvalid", 32'(resp_valid), 32'b1000);
        checkOutput("to_err", 32'(resp_err), 32'd1);
        checkOutput("to_z", 32'(resp_z), 32'd0);
        step();
        mm_enable = 1'b1;
        applyStimulus(0, 8'd3, 8'd3);
        applyStimulus(3, 8'd2, 8'd2);
        serve("to_next", 0, 8'd3, 8'd3, 16'h0009);

        // Reset mid-operation: requester 3 is accepted now, reset hits in BUSY
        settle();
        checkOutput("rb_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        repeat (4) step();
        rst       = 1'b1;
        req_valid = 4'b0001;
        settle();
        checkOutput("rb_busy", 32'(busy), 32'd0);
        checkOutput("rb_rvalid", 32'(resp_valid), 32'd0);
        checkOutput("rb_start", 32'(mul_start), 32'd0);
        checkOutput("rb_mulx", 32'(mul_x), 32'd0);
        checkOutput("rb_muly", 32'(mul_y), 32'd0);
        checkOutput("rb_ready_low", 32'(req_ready), 32'd0);
        step();
        rst       = 1'b0;
        req_valid = '0;
        step();
        step();
        applyStimulus(0, 8'd7, 8'hFA);
        serve("rst_next", 0, 8'd7, 8'hFA, 16'hFFD6);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
